pmp_csr_initiator: RTL and testbench

Requester side of the PMP CSR request/response interface. It sits in the core's execute stage. It accepts one decoded Zicsr instruction at a time from the issue logic, derives the read/write op, and drives a single-cycle `csr_req_en` request to the PMP CSR responder. It captures the response, releases the responder with a one-cycle `csr_rrsp` pulse, and hands the result (or an exception) to writeback over a valid/ready handshake. One transaction is outstanding at a time; a timeout guards against a silent responder.

---
 rtl/pmp_csr_initiator_if.sv | 26 ++
 rtl/pmp_csr_initiator.sv | 146 ++++++++++++++
 tb/tb_pmp_csr_initiator.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pmp_csr_initiator_if.sv
// Request/response bus between the execute-stage CSR initiator and the PMP CSR responder.
// The master modport is the initiator's view; the slave modport is the responder's.
interface pmp_csr_initiator_if #(
    parameter int REG_WIDTH = 32
);
    logic                 csr_req_en;
    logic [1:0]           csr_req_op;
    logic [2:0]           csr_funct3;
    logic [4:0]           csr_imm;
    logic [REG_WIDTH-1:0] rs1_val;
    logic [11:0]          csr_req_addr;
    logic                 csr_rrsp;
    logic [31:0]          csr_req_rdata;
    logic                 csr_req_rvalid;
    logic [2:0]           csr_act_rsp;

    modport master (
        output csr_req_en, csr_req_op, csr_funct3, csr_imm, rs1_val, csr_req_addr, csr_rrsp,
        input  csr_req_rdata, csr_req_rvalid, csr_act_rsp
    );

    modport slave (
        input  csr_req_en, csr_req_op, csr_funct3, csr_imm, rs1_val, csr_req_addr, csr_rrsp,
        output csr_req_rdata, csr_req_rvalid, csr_act_rsp
    );
endinterface

// File: rtl/pmp_csr_initiator.sv
// Execute-stage PMP CSR requester: one Zicsr instruction in flight, single-cycle request,
// response capture with timeout, one-cycle responder release, valid/ready writeback.
module pmp_csr_initiator #(
    parameter int REG_WIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [2:0]           issue_funct3,
    input  logic [11:0]          issue_csr_addr,
    input  logic [4:0]           issue_rs1_idx,
    input  logic [4:0]           issue_rd_idx,
    input  logic [REG_WIDTH-1:0] issue_rs1_val,
    input  logic                 flush,
    pmp_csr_initiator_if.master  csr,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [4:0]           wb_rd_idx,
    output logic [REG_WIDTH-1:0] wb_data,
    output logic                 wb_we,
    output logic                 wb_exc,
    output logic                 wb_timeout
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RELEASE, S_WB} state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [2:0]           funct3_q;
    logic [11:0]          addr_q;
    logic [4:0]           rs1_idx_q, rd_idx_q;
    logic [REG_WIDTH-1:0] rs1_val_q;
    logic [1:0]           op_q;
    logic [31:0]          rdata_q;
    logic [7:0]           cnt_q;
    logic                 exc_q, timeout_q, flush_pend_q;

    logic illegal, op_rd, op_wr, req_en, rrsp, unused_rsp;

    // funct3 x00 has no Zicsr meaning; the op bits follow the "no side effect" rules.
    assign illegal    = (issue_funct3[1:0] == 2'b00);
    assign op_rd      = !(issue_funct3[1:0] == 2'b01 && issue_rd_idx == 5'd0);
    assign op_wr      = !(issue_funct3[1] && issue_rs1_idx == 5'd0);
    assign unused_rsp = csr.csr_act_rsp[2] ^ csr.csr_act_rsp[0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: next-state defaults to the current state first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (issue_valid) state_d = illegal ? S_WB : S_REQ;
            S_REQ:     state_d = csr.csr_req_rvalid ? S_RELEASE : S_WAIT;
            S_WAIT:    if (csr.csr_req_rvalid || cnt_q == TMO_LAST) state_d = S_RELEASE;
            S_RELEASE: state_d = (flush_pend_q || flush) ? S_IDLE : S_WB;
            S_WB:      if (wb_ready || flush) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue_ready = 1'b0;
        req_en      = 1'b0;
        rrsp        = 1'b0;
        wb_valid    = 1'b0;
        unique case (state_q)
            S_IDLE:    issue_ready = 1'b1;
            S_REQ:     req_en      = 1'b1;
            S_RELEASE: rrsp        = 1'b1;
            S_WB:      wb_valid    = 1'b1;
            default:   ;
        endcase
    end

    // NOTE: every latched field is reset so all data/address outputs read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q  <= '0;
            addr_q    <= '0;
            rs1_idx_q <= '0;
            rd_idx_q  <= '0;
            rs1_val_q <= '0;
            op_q      <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            exc_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (issue_valid) begin
                    funct3_q  <= issue_funct3;
                    addr_q    <= issue_csr_addr;
                    rs1_idx_q <= issue_rs1_idx;
                    rd_idx_q  <= issue_rd_idx;
                    rs1_val_q <= issue_rs1_val;
                    op_q      <= {op_rd, op_wr};
                    rdata_q   <= '0;
                    exc_q     <= illegal;
                    timeout_q <= 1'b0;
                end
                S_REQ, S_WAIT: begin
                    // A response arriving on the final WAIT cycle beats the timeout.
                    if (csr.csr_req_rvalid) begin
                        if (op_q[1]) rdata_q <= csr.csr_req_rdata;
                        exc_q <= csr.csr_act_rsp[1];
                    end else if (state_q == S_WAIT && cnt_q == TMO_LAST) begin
                        exc_q     <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                    cnt_q <= (state_q == S_REQ) ? 8'd0 : cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // A kill seen while the bus is busy is remembered until the transaction drains to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flush_pend_q <= 1'b0;
        else if (state_d == S_IDLE)
            flush_pend_q <= 1'b0;
        else if (flush && (state_q == S_REQ || state_q == S_WAIT || state_q == S_RELEASE))
            flush_pend_q <= 1'b1;
    end

    assign csr.csr_req_en   = req_en;
    assign csr.csr_rrsp     = rrsp;
    assign csr.csr_req_op   = op_q;
    assign csr.csr_funct3   = funct3_q;
    assign csr.csr_imm      = rs1_idx_q;
    assign csr.rs1_val      = rs1_val_q;
    assign csr.csr_req_addr = addr_q;

    assign wb_rd_idx  = rd_idx_q;
    assign wb_we      = wb_valid & ~exc_q & op_q[1] & (rd_idx_q != 5'd0);
    assign wb_exc     = wb_valid & exc_q;
    assign wb_timeout = wb_valid & timeout_q;
    assign wb_data    = (wb_valid && !exc_q && op_q[1]) ? REG_WIDTH'(rdata_q) : '0;
endmodule

// File: tb/tb_pmp_csr_initiator.sv
// Bench for pmp_csr_initiator: directed cases plus random transactions scored against
// a per-transaction timeline model (event cycles and writeback contents).
module tb_pmp_csr_initiator;
  localparam int RW    = 32;
  localparam int TMO   = 16;
  localparam int NEVER = 1000;

  typedef struct {
    logic [2:0]    f3;
    logic [11:0]   addr;
    logic [4:0]    rs1_idx;
    logic [4:0]    rd_idx;
    logic [RW-1:0] rs1v;
    int            lat;
    logic [31:0]   rdata;
    bit            rsp_exc;
    int            bp;
    int            flush_at;
    bit            flush_wb;
    bit            flush_issue;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [2:0]    issue_funct3 = '0;
  logic [11:0]   issue_csr_addr = '0;
  logic [4:0]    issue_rs1_idx = '0;
  logic [4:0]    issue_rd_idx = '0;
  logic [RW-1:0] issue_rs1_val = '0;
  logic          flush = 1'b0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [4:0]    wb_rd_idx;
  logic [RW-1:0] wb_data;
  logic          wb_we, wb_exc, wb_timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pmp_csr_initiator_if #(.REG_WIDTH(RW)) csr_if ();

  pmp_csr_initiator #(.REG_WIDTH(RW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_funct3(issue_funct3),
    .issue_csr_addr(issue_csr_addr), .issue_rs1_idx(issue_rs1_idx), .issue_rd_idx(issue_rd_idx),
    .issue_rs1_val(issue_rs1_val), .flush(flush), .csr(csr_if),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_idx(wb_rd_idx), .wb_data(wb_data),
    .wb_we(wb_we), .wb_exc(wb_exc), .wb_timeout(wb_timeout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic txn_t base_txn();
    txn_t t;
    t.f3 = 3'b010; t.addr = '0; t.rs1_idx = '0; t.rd_idx = '0; t.rs1v = '0;
    t.lat = 0; t.rdata = '0; t.rsp_exc = 1'b0; t.bp = 0;
    t.flush_at = 0; t.flush_wb = 1'b0; t.flush_issue = 1'b0;
    return t;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after.
  task automatic run_txn(input txn_t t);
    bit illegal, rd, wr, to, early, fwb, exc, exp_we, rv;
    int rrsp_k, wb_k, end_k, exp_wb_n;
    int n_req, n_rrsp, n_wb, first_rrsp, first_wb;
    bit bus_bad, wb_bad, ready_bad;
    logic [RW+21:0] exp_bus, got_bus;
    logic [RW+7:0]  exp_wb, got_wb, wb_first_val;
    logic [RW-1:0]  exp_data;

    // Reference timeline, counted in cycles after the accept cycle T.
    illegal  = (t.f3[1:0] == 2'b00);
    rd       = !(t.f3[1:0] == 2'b01 && t.rd_idx == 5'd0);
    wr       = !(t.f3[1] && t.rs1_idx == 5'd0);
    to       = !illegal && t.lat > TMO;
    rrsp_k   = illegal ? 0 : (to ? TMO + 2 : t.lat + 2);
    early    = !illegal && t.flush_at >= 1 && t.flush_at <= rrsp_k;
    fwb      = t.flush_wb && !early;
    exc      = illegal || to || t.rsp_exc;
    wb_k     = illegal ? 1 : rrsp_k + 1;
    end_k    = early ? rrsp_k + 1 : (fwb ? wb_k + 1 : wb_k + t.bp + 1);
    exp_wb_n = early ? 0 : (fwb ? 1 : t.bp + 1);
    exp_we   = !exc && rd && t.rd_idx != 5'd0;
    exp_data = (exc || !rd) ? '0 : RW'(t.rdata);
    exp_bus  = {rd, wr, t.f3, t.addr, t.rs1_idx, t.rs1v};
    exp_wb   = {t.rd_idx, exp_data, exp_we, exc, to};

    n_req = 0; n_rrsp = 0; n_wb = 0; first_rrsp = 0; first_wb = 0;
    bus_bad = 1'b0; wb_bad = 1'b0; ready_bad = 1'b0; wb_first_val = '0;

    check("issue_ready_at_T", 64'(issue_ready), 64'd1);
    issue_valid = 1'b1; issue_funct3 = t.f3; issue_csr_addr = t.addr;
    issue_rs1_idx = t.rs1_idx; issue_rd_idx = t.rd_idx; issue_rs1_val = t.rs1v;
    flush = t.flush_issue;

    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      if (k == end_k) begin
        check("idle_after_txn", 64'({issue_ready, wb_valid, csr_if.csr_req_en, csr_if.csr_rrsp}), 64'b1000);
      end else begin
        if (issue_ready) ready_bad = 1'b1;
        if (csr_if.csr_req_en) n_req++;
        if (csr_if.csr_rrsp) begin
          n_rrsp++;
          if (first_rrsp == 0) first_rrsp = k;
        end
        got_bus = {csr_if.csr_req_op, csr_if.csr_funct3, csr_if.csr_req_addr, csr_if.csr_imm, csr_if.rs1_val};
        if (!illegal && k <= rrsp_k && got_bus !== exp_bus) bus_bad = 1'b1;
        if (k == 1) begin
          check("req_en_at_T+1", 64'(csr_if.csr_req_en), 64'(!illegal));
          if (!illegal) begin
            check("req_op", 64'(csr_if.csr_req_op), 64'({rd, wr}));
            check("req_addr", 64'(csr_if.csr_req_addr), 64'(t.addr));
            check("req_imm", 64'(csr_if.csr_imm), 64'(t.rs1_idx));
            check("req_rs1_val", 64'(csr_if.rs1_val), 64'(t.rs1v));
          end
        end
        got_wb = {wb_rd_idx, wb_data, wb_we, wb_exc, wb_timeout};
        if (wb_valid) begin
          n_wb++;
          if (first_wb == 0) begin
            first_wb = k;
            wb_first_val = got_wb;
          end
          if (got_wb !== exp_wb) wb_bad = 1'b1;
        end
      end
      // Inputs for cycle k: sticky responder valid until the release, junk otherwise.
      issue_valid = 1'b0;
      rv = !illegal && k >= 1 + t.lat && k <= rrsp_k;
      csr_if.csr_req_rvalid = rv;
      csr_if.csr_req_rdata  = rv ? t.rdata : $urandom;
      csr_if.csr_act_rsp    = rv ? (t.rsp_exc ? 3'b010 : 3'b000) : 3'($urandom);
      flush    = (early && k == t.flush_at) || (fwb && k == wb_k);
      wb_ready = !fwb && k >= wb_k + t.bp && k < end_k;
    end

    check("req_en_count", 64'(n_req), illegal ? 64'd0 : 64'd1);
    check("rrsp_count", 64'(n_rrsp), illegal ? 64'd0 : 64'd1);
    if (!illegal) check("rrsp_cycle", 64'(first_rrsp), 64'(rrsp_k));
    check("wb_valid_cycles", 64'(n_wb), 64'(exp_wb_n));
    if (exp_wb_n > 0) begin
      check("wb_first_cycle", 64'(first_wb), 64'(wb_k));
      check("wb_rd_idx", 64'(wb_first_val[RW+7:RW+3]), 64'(t.rd_idx));
      check("wb_data", 64'(wb_first_val[RW+2:3]), 64'(exp_data));
      check("wb_we", 64'(wb_first_val[2]), 64'(exp_we));
      check("wb_exc", 64'(wb_first_val[1]), 64'(exc));
      check("wb_timeout", 64'(wb_first_val[0]), 64'(to));
    end
    check("bus_stable", 64'(bus_bad), 64'd0);
    check("wb_stable", 64'(wb_bad), 64'd0);
    check("issue_ready_low_busy", 64'(ready_bad), 64'd0);
  endtask

  task automatic reset_mid_txn();
    issue_valid = 1'b1; issue_funct3 = 3'b011; issue_csr_addr = 12'h3A5;
    issue_rs1_idx = 5'd3; issue_rd_idx = 5'd7; issue_rs1_val = 32'hDEAD_BEEF;
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_ctrl", 64'({issue_ready, csr_if.csr_req_en, csr_if.csr_rrsp, wb_valid}), 64'b1000);
    check("midreset_addr", 64'(csr_if.csr_req_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_no_rrsp", 64'({issue_ready, csr_if.csr_rrsp}), 64'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    txn_t t;
    int lat_tab[8];
    lat_tab = '{0, 1, 2, 3, TMO - 1, TMO, TMO + 1, NEVER};
    csr_if.csr_req_rvalid = 1'b0;
    csr_if.csr_req_rdata  = '0;
    csr_if.csr_act_rsp    = '0;

    #1;
    check("reset_ctrl", 64'({issue_ready, csr_if.csr_req_en, csr_if.csr_rrsp, wb_valid, wb_we, wb_exc, wb_timeout}), 64'b1000000);
    check("reset_data", 64'({wb_data, wb_rd_idx, csr_if.csr_req_op, csr_if.csr_funct3, csr_if.csr_imm}), 64'd0);
    check("reset_bus", 64'({csr_if.rs1_val, csr_if.csr_req_addr}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    t = base_txn(); t.f3 = 3'b010; t.addr = 12'h3A0; t.rd_idx = 5'd5; t.rdata = 32'h0F0F_0F0F;
    run_txn(t);
    t = base_txn(); t.f3 = 3'b001; t.addr = 12'h3B0; t.rs1_idx = 5'd7; t.rs1v = 32'h1234; t.rdata = 32'hAAAA_5555;
    run_txn(t);
    t = base_txn(); t.f3 = 3'b011; t.addr = 12'h3C4; t.rs1_idx = 5'd3; t.rd_idx = 5'd6; t.rdata = 32'h1111_2222; t.rsp_exc = 1'b1;
    run_txn(t);
    t = base_txn(); t.f3 = 3'b010; t.addr = 12'h3A1; t.rs1_idx = 5'd2; t.rd_idx = 5'd9; t.rdata = 32'hCAFE_F00D; t.lat = 3; t.bp = 3;
    run_txn(t);
    t = base_txn(); t.f3 = 3'b110; t.addr = 12'h3A2; t.rs1_idx = 5'd4; t.rd_idx = 5'd1; t.lat = NEVER;
    run_txn(t);
    t = base_txn(); t.f3 = 3'b111; t.addr = 12'h3B1; t.rs1_idx = 5'd1; t.rd_idx = 5'd2; t.rdata = 32'h7777_0001; t.lat = TMO;
    run_txn(t);
    t = base_txn(); t.f3 = 3'b010; t.addr = 12'h3A3; t.rs1_idx = 5'd8; t.rd_idx = 5'd3; t.rdata = 32'h0BAD_0BAD; t.lat = 5; t.flush_at = 3;
    run_txn(t);
    t = base_txn(); t.f3 = 3'b100; t.addr = 12'h3A0; t.rs1_idx = 5'd9; t.rd_idx = 5'd4;
    run_txn(t);
    t = base_txn(); t.f3 = 3'b101; t.addr = 12'h3B2; t.rs1_idx = 5'd6; t.rd_idx = 5'd10; t.rdata = 32'h5; t.flush_wb = 1'b1; t.bp = 2;
    run_txn(t);

    reset_mid_txn();

    for (int i = 0; i < 150; i++) begin
      t = base_txn();
      t.f3          = 3'($urandom_range(0, 7));
      t.addr        = 12'($urandom);
      t.rs1_idx     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      t.rd_idx      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      t.rs1v        = RW'($urandom);
      t.lat         = lat_tab[$urandom_range(0, 7)];
      t.rdata       = $urandom;
      t.rsp_exc     = ($urandom_range(0, 4) == 0);
      t.bp          = $urandom_range(0, 3);
      t.flush_at    = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 20) : 0;
      t.flush_wb    = ($urandom_range(0, 7) == 0);
      t.flush_issue = ($urandom_range(0, 4) == 0);
      run_txn(t);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
